ddr2_port_arbiter: RTL and testbench
====================================

Name: ddr2_port_arbiter

Overview:
- Shares the single DDR2 controller user port between two requesters: the VGA line-fetch reader (rd_*) and the fractal pixel writer (wr_*).
- Sits in the memory clock domain, between the requester-side clock-crossing FIFOs and the DDR2 controller inside fractal_top.
- Read priority keeps the display fed. A starvation limit guarantees the writer forward progress.
- One transaction outstanding at a time: command, then data beats, then the next grant.

Parameters:
ADDR_W, 25, burst start address width (word address)
DATA_W, 32, user data word width
LEN_W, 6, burst length field; value N means N+1 beats
STARVE_LIMIT, 4, consecutive read grants allowed while wr_req is pending before a write is forced

Ports:
mem_clk_s  in  1  memory-domain clock, rising edge
mem_rst_s_n  in  1  asynchronous active-low reset
init_done  in  1  DDR2 controller calibrated; no grant while low
rd_req  in  1  reader request; held until rd_gnt
rd_addr  in  ADDR_W  reader burst address
rd_len  in  LEN_W  reader beats-1
rd_gnt  out  1  one-cycle pulse when the read command is accepted by the controller
rd_data  out  DATA_W  read beat to reader
rd_data_valid  out  1  rd_data qualifier
rd_done  out  1  one-cycle pulse on the last read beat
wr_req  in  1  writer request; held until wr_gnt
wr_addr  in  ADDR_W  writer burst address
wr_len  in  LEN_W  writer beats-1
wr_gnt  out  1  one-cycle pulse when the write command is accepted
wr_data  in  DATA_W  write beat from writer
wr_data_valid  in  1  wr_data qualifier
wr_data_rdy  out  1  writer beat consumed this cycle when wr_data_valid is high
wr_done  out  1  one-cycle pulse on the last write beat
mc_cmd_valid  out  1  command to controller
mc_cmd_ready  in  1  controller accepts command
mc_cmd_write  out  1  1 = write, 0 = read
mc_cmd_addr  out  ADDR_W  registered burst address
mc_cmd_len  out  LEN_W  registered beats-1
mc_wr_data  out  DATA_W  write beat to controller
mc_wr_data_valid  out  1  write beat qualifier
mc_wr_data_rdy  in  1  controller accepts write beat
mc_rd_data  in  DATA_W  read beat from controller
mc_rd_data_valid  in  1  read beat qualifier
busy  out  1  state != IDLE
err_stray  out  1  sticky: mc_rd_data_valid seen outside RDATA; cleared only by reset

Behaviour:
- Reset (mem_rst_s_n low, asynchronous):
  - State = IDLE; beat counter, streak counter and err_stray cleared.
  - All outputs 0, including mc_cmd_addr and mc_cmd_len.
  - Reset mid-transaction abandons the transaction; requesters re-issue.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE: arbitration runs only when init_done=1.
  - Grant write if wr_req and (!rd_req or streak==STARVE_LIMIT).
  - Else grant read if rd_req.
  - On grant, register addr, len and direction, then go to CMD. mc_cmd_valid rises on the cycle after the request is sampled.
- CMD: hold mc_cmd_valid with stable fields until mc_cmd_ready.
  - On the accept cycle, pulse rd_gnt or wr_gnt.
  - Go to WDATA or RDATA; load beat counter = len.
- WDATA:
  - Combinational pass-through: mc_wr_data = wr_data; mc_wr_data_valid = wr_data_valid; wr_data_rdy = mc_wr_data_rdy.
  - A beat completes when wr_data_valid & mc_wr_data_rdy; each completed beat decrements the counter.
  - The completed beat with counter==0 pulses wr_done and returns to IDLE.
  - Outside WDATA, mc_wr_data_valid and wr_data_rdy are 0.
- RDATA:
  - Combinational pass-through: rd_data = mc_rd_data; rd_data_valid = mc_rd_data_valid.
  - Count beats; the last beat pulses rd_done and returns to IDLE.
  - Outside RDATA, rd_data_valid = 0 and any mc_rd_data_valid sets err_stray.
- Streak counter, width clog2(STARVE_LIMIT+1):
  - On a read grant with wr_req high: increment, saturating at STARVE_LIMIT.
  - On a read grant with wr_req low: clear.
  - On any write grant: clear.
- Simultaneous rd_req and wr_req: read wins unless streak==STARVE_LIMIT.
- init_done falling mid-transaction: the transaction completes; no new grant until it returns high.
- len=0 means a single beat; len=2^LEN_W-1 means 64 beats. The counter never wraps.
- Minimum back-to-back spacing: 1 IDLE cycle between transactions.

Decomposition:
- Shared package ddr2_arb_pkg holds:
  - State encoding constants (IDLE, CMD, WDATA, RDATA).
  - Direction constants (DIR_RD, DIR_WR).
  - Default ADDR_W, DATA_W, LEN_W.
- One natural sub-module, ddr2_arb_prio: the grant decision plus streak counter.
  - Inputs: rd_req, wr_req, init_done, grant strobe.
  - Outputs: grant_rd, grant_wr.
- FSM and datapath muxing stay in the top module.

Test Plan:
1. Reset with init_done=0 and rd_req=1 -> no mc_cmd_valid. Raise init_done -> mc_cmd_valid=1, write=0, with rd_addr and rd_len, on the next cycle.
2. Read of rd_len=3, mc_cmd_ready delayed 5 cycles -> fields stable throughout; rd_gnt pulses once; 4 beats forwarded; rd_done coincides with the 4th beat; busy drops the following cycle.
3. Write of wr_len=7 with random gaps on wr_data_valid and mc_wr_data_rdy -> exactly 8 beats transferred in order, values 0x100..0x107; wr_done on the 8th; no extra wr_data_rdy.
4. rd_req and wr_req continuously high, STARVE_LIMIT=4 -> grant order R,R,R,R,W,R,R,R,R,W…
5. mc_rd_data_valid pulsed while in IDLE -> err_stray=1 and stays set; rd_data_valid stays 0.
6. Assert mem_rst_s_n=0 mid-way through a write (beat 3 of 8) -> all outputs 0 immediately. After release, a fresh wr_req is granted normally with counter = len.

Source files
------------

// File: rtl/ddr2_arb_pkg.sv
// Shared definitions for the DDR2 user-port arbiter.
// Holds the FSM state encoding, the transfer-direction constants and the
// default widths used by ddr2_port_arbiter and ddr2_arb_prio.
package ddr2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int DEF_ADDR_W       = 25;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_LEN_W        = 6;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/ddr2_arb_prio.sv
// Grant decision and writer-starvation streak counter.
// Ports:
//   clk, rst_n       memory clock, async active-low reset
//   init_done        controller calibrated; no grant while low
//   rd_req, wr_req   pending requests
//   grant_stb        high while the arbiter is able to take a grant (IDLE)
//   grant_rd/wr      combinational grant decision for this cycle
module ddr2_arb_prio
    import ddr2_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_done,
    input  logic rd_req,
    input  logic wr_req,
    input  logic grant_stb,
    output logic grant_rd,
    output logic grant_wr
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                starved;

    // Grant decision: reads win unless the writer has waited out the streak.
    always_comb begin
        starved  = (streak_q == LIMIT);
        grant_wr = init_done & wr_req & (~rd_req | starved);
        grant_rd = init_done & rd_req & ~(wr_req & starved);
    end

    // Streak update: only reads granted over a pending write extend it.
    always_comb begin
        streak_d = streak_q;
        if (grant_stb && grant_wr) begin
            streak_d = '0;
        end else if (grant_stb && grant_rd) begin
            if (!wr_req) begin
                streak_d = '0;
            end else if (starved) begin
                streak_d = LIMIT;
            end else begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Shares the DDR2 controller user port between the VGA line reader (rd_*)
// and the fractal pixel writer (wr_*), one burst outstanding at a time.
// Ports:
//   mem_clk_s, mem_rst_s_n   memory clock / async active-low reset
//   init_done                controller calibrated
//   rd_* / wr_*              requester command, grant, data and done strobes
//   mc_*                     controller command, write-data and read-data ports
//   busy                     transaction in progress
//   err_stray                sticky: read beat seen outside a read burst
module ddr2_port_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              mem_clk_s,
    input  logic              mem_rst_s_n,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_gnt,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    output logic              wr_data_rdy,
    output logic              wr_done,
    output logic              mc_cmd_valid,
    input  logic              mc_cmd_ready,
    output logic              mc_cmd_write,
    output logic [ADDR_W-1:0] mc_cmd_addr,
    output logic [LEN_W-1:0]  mc_cmd_len,
    output logic [DATA_W-1:0] mc_wr_data,
    output logic              mc_wr_data_valid,
    input  logic              mc_wr_data_rdy,
    input  logic [DATA_W-1:0] mc_rd_data,
    input  logic              mc_rd_data_valid,
    output logic              busy,
    output logic              err_stray
);

    arb_state_e        state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic grant_rd, grant_wr;
    logic in_idle, in_cmd, in_wdata, in_rdata;
    logic wr_beat, rd_beat, last_beat;

    ddr2_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk      (mem_clk_s),
        .rst_n    (mem_rst_s_n),
        .init_done(init_done),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .grant_stb(in_idle),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // State decode, beat detection and requester/controller port muxing.
    always_comb begin
        in_idle   = (state_q == IDLE);
        in_cmd    = (state_q == CMD);
        in_wdata  = (state_q == WDATA);
        in_rdata  = (state_q == RDATA);
        wr_beat   = in_wdata & wr_data_valid & mc_wr_data_rdy;
        rd_beat   = in_rdata & mc_rd_data_valid;
        last_beat = (cnt_q == '0);

        mc_cmd_valid     = in_cmd;
        mc_cmd_write     = dir_q;
        mc_cmd_addr      = addr_q;
        mc_cmd_len       = len_q;
        rd_gnt           = in_cmd & mc_cmd_ready & (dir_q == DIR_RD);
        wr_gnt           = in_cmd & mc_cmd_ready & (dir_q == DIR_WR);
        // Data paths are gated so nothing leaks out while idle or in reset.
        mc_wr_data       = in_wdata ? wr_data : '0;
        mc_wr_data_valid = in_wdata & wr_data_valid;
        wr_data_rdy      = in_wdata & mc_wr_data_rdy;
        wr_done          = wr_beat & last_beat;
        rd_data          = in_rdata ? mc_rd_data : '0;
        rd_data_valid    = rd_beat;
        rd_done          = rd_beat & last_beat;
        busy             = ~in_idle;
        err_stray        = err_q;
    end

    // Next-state and command/counter register updates.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (mc_rd_data_valid & ~in_rdata);
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    dir_d   = DIR_WR;
                    addr_d  = wr_addr;
                    len_d   = wr_len;
                    state_d = CMD;
                end else if (grant_rd) begin
                    dir_d   = DIR_RD;
                    addr_d  = rd_addr;
                    len_d   = rd_len;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (mc_cmd_ready) begin
                    cnt_d   = len_q;
                    state_d = (dir_q == DIR_WR) ? WDATA : RDATA;
                end else begin
                    state_d = CMD;
                end
            end
            WDATA, RDATA: begin
                // Counter stops at zero: the last beat leaves instead of wrapping.
                if (wr_beat || rd_beat) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge mem_clk_s or negedge mem_rst_s_n) begin
        if (!mem_rst_s_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_RD;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Directed self-checking bench for ddr2_port_arbiter with a data scoreboard.
module tb_ddr2_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    logic              mem_clk_s = 1'b0;
    logic              mem_rst_s_n;
    logic              init_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_gnt;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid;
    logic              wr_data_rdy;
    logic              wr_done;
    logic              mc_cmd_valid;
    logic              mc_cmd_ready;
    logic              mc_cmd_write;
    logic [ADDR_W-1:0] mc_cmd_addr;
    logic [LEN_W-1:0]  mc_cmd_len;
    logic [DATA_W-1:0] mc_wr_data;
    logic              mc_wr_data_valid;
    logic              mc_wr_data_rdy;
    logic [DATA_W-1:0] mc_rd_data;
    logic              mc_rd_data_valid;
    logic              busy;
    logic              err_stray;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 mem_clk_s = ~mem_clk_s;

    ddr2_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .STARVE_LIMIT(4)
    ) dut (
        .mem_clk_s(mem_clk_s), .mem_rst_s_n(mem_rst_s_n), .init_done(init_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_rdy(wr_data_rdy),
        .wr_done(wr_done), .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready),
        .mc_cmd_write(mc_cmd_write), .mc_cmd_addr(mc_cmd_addr), .mc_cmd_len(mc_cmd_len),
        .mc_wr_data(mc_wr_data), .mc_wr_data_valid(mc_wr_data_valid),
        .mc_wr_data_rdy(mc_wr_data_rdy), .mc_rd_data(mc_rd_data),
        .mc_rd_data_valid(mc_rd_data_valid), .busy(busy), .err_stray(err_stray)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge mem_clk_s);
        #1;
    endtask

    // One burst from request to done; stop_after>0 abandons after that many beats.
    task automatic run_txn(input bit exp_wr, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] base,
                           input int ready_delay, input bit keep_req, input int stop_after);
        int k;
        int guard;
        check("idle_before_cmd", 64'(busy), 64'd0);
        if (exp_wr) begin
            wr_req = 1'b1; wr_addr = addr; wr_len = len;
        end else begin
            rd_req = 1'b1; rd_addr = addr; rd_len = len;
        end
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(base + DATA_W'(i));
        mc_cmd_ready = 1'b0;
        step();
        check("cmd_valid", 64'(mc_cmd_valid), 64'd1);
        check("cmd_write", 64'(mc_cmd_write), 64'(exp_wr));
        check("cmd_addr", 64'(mc_cmd_addr), 64'(addr));
        check("cmd_len", 64'(mc_cmd_len), 64'(len));
        repeat (ready_delay) begin
            step();
            check("cmd_hold_valid", 64'(mc_cmd_valid), 64'd1);
            check("cmd_hold_addr", 64'(mc_cmd_addr), 64'(addr));
            check("cmd_hold_len", 64'(mc_cmd_len), 64'(len));
            check("gnt_early", 64'(rd_gnt | wr_gnt), 64'd0);
        end
        mc_cmd_ready = 1'b1;
        #1;
        check("rd_gnt", 64'(rd_gnt), 64'(!exp_wr));
        check("wr_gnt", 64'(wr_gnt), 64'(exp_wr));
        step();
        mc_cmd_ready = 1'b0;
        if (!keep_req) begin
            if (exp_wr) wr_req = 1'b0;
            else        rd_req = 1'b0;
        end
        check("gnt_once", 64'(rd_gnt | wr_gnt), 64'd0);
        k = 0;
        guard = 0;
        while (k <= int'(len) && guard < 400 && !(stop_after > 0 && k == stop_after)) begin
            guard++;
            if (exp_wr) begin
                wr_data_valid  = ($urandom_range(0, 3) != 0);
                mc_wr_data_rdy = ($urandom_range(0, 3) != 0);
                wr_data        = base + DATA_W'(k);
                #1;
                check("wr_pass_valid", 64'(mc_wr_data_valid), 64'(wr_data_valid));
                check("wr_pass_rdy", 64'(wr_data_rdy), 64'(mc_wr_data_rdy));
                if (wr_data_valid && mc_wr_data_rdy) begin
                    check("wr_beat", 64'(mc_wr_data), 64'(exp_q.pop_front()));
                    check("wr_done", 64'(wr_done), 64'(k == int'(len)));
                    k++;
                end else begin
                    check("wr_done_gap", 64'(wr_done), 64'd0);
                end
            end else begin
                mc_rd_data_valid = ($urandom_range(0, 3) != 0);
                mc_rd_data       = base + DATA_W'(k);
                #1;
                check("rd_pass_valid", 64'(rd_data_valid), 64'(mc_rd_data_valid));
                if (mc_rd_data_valid) begin
                    check("rd_beat", 64'(rd_data), 64'(exp_q.pop_front()));
                    check("rd_done", 64'(rd_done), 64'(k == int'(len)));
                    k++;
                end else begin
                    check("rd_done_gap", 64'(rd_done), 64'd0);
                end
            end
            step();
        end
        wr_data_valid    = 1'b0;
        mc_wr_data_rdy   = 1'b0;
        mc_rd_data_valid = 1'b0;
        if (stop_after > 0 && k == stop_after) return;
        check("beat_count", 64'(k), 64'(int'(len) + 1));
        check("busy_drop", 64'(busy), 64'd0);
        // No write handshake may leak once the burst is over.
        wr_data_valid  = 1'b1;
        mc_wr_data_rdy = 1'b1;
        #1;
        check("no_extra_rdy", 64'(wr_data_rdy), 64'd0);
        check("no_extra_wvalid", 64'(mc_wr_data_valid), 64'd0);
        wr_data_valid  = 1'b0;
        mc_wr_data_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        mem_rst_s_n = 1'b0; init_done = 1'b0;
        rd_req = 1'b1; rd_addr = 25'h0ABCDE; rd_len = 6'd3;
        wr_req = 1'b0; wr_addr = '0; wr_len = '0;
        wr_data = '0; wr_data_valid = 1'b0;
        mc_cmd_ready = 1'b0; mc_wr_data_rdy = 1'b0;
        mc_rd_data = '0; mc_rd_data_valid = 1'b0;

        // Reset state, then no grant while init_done is low.
        step();
        check("rst_cmd_valid", 64'(mc_cmd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_addr", 64'(mc_cmd_addr), 64'd0);
        check("rst_err", 64'(err_stray), 64'd0);
        mem_rst_s_n = 1'b1;
        repeat (3) begin
            step();
            check("no_init_cmd", 64'(mc_cmd_valid), 64'd0);
        end

        // init_done rises; read of 4 beats with a 5-cycle command stall.
        init_done = 1'b1;
        run_txn(1'b0, 25'h0ABCDE, 6'd3, 32'hA000, 5, 1'b0, 0);

        // Write of 8 beats with random handshake gaps.
        run_txn(1'b1, 25'h012345, 6'd7, 32'h100, 0, 1'b0, 0);

        // Both requesters continuously pending: R,R,R,R,W repeating.
        rd_req = 1'b1; wr_req = 1'b1;
        rd_addr = 25'h1111; wr_addr = 25'h2222; rd_len = 6'd1; wr_len = 6'd1;
        for (int i = 0; i < 10; i++) begin
            run_txn((i % 5) == 4, ((i % 5) == 4) ? 25'h2222 : 25'h1111, 6'd1,
                    32'h200 + 32'(i * 16), 0, 1'b1, 0);
        end
        rd_req = 1'b0; wr_req = 1'b0;

        // Stray read beat while idle sets the sticky error.
        step();
        check("err_clear", 64'(err_stray), 64'd0);
        mc_rd_data = 32'hDEAD; mc_rd_data_valid = 1'b1;
        #1;
        check("stray_rd_valid", 64'(rd_data_valid), 64'd0);
        step();
        mc_rd_data_valid = 1'b0;
        check("err_set", 64'(err_stray), 64'd1);
        repeat (2) step();
        check("err_sticky", 64'(err_stray), 64'd1);

        // Reset in the middle of a write burst, then a fresh 8-beat write.
        run_txn(1'b1, 25'h0F0F0, 6'd7, 32'h300, 0, 1'b0, 3);
        wr_data_valid = 1'b1; mc_wr_data_rdy = 1'b1; wr_data = 32'hFFFF;
        mem_rst_s_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wvalid", 64'(mc_wr_data_valid), 64'd0);
        check("mid_rst_wrdy", 64'(wr_data_rdy), 64'd0);
        check("mid_rst_wdata", 64'(mc_wr_data), 64'd0);
        check("mid_rst_addr", 64'(mc_cmd_addr), 64'd0);
        check("mid_rst_len", 64'(mc_cmd_len), 64'd0);
        check("mid_rst_write", 64'(mc_cmd_write), 64'd0);
        check("mid_rst_err", 64'(err_stray), 64'd0);
        exp_q.delete();
        step();
        mem_rst_s_n = 1'b1; wr_data_valid = 1'b0; mc_wr_data_rdy = 1'b0;
        step();
        run_txn(1'b1, 25'h1ABCD, 6'd7, 32'h400, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
